// File: rtl/match_window_counter.sv
// Counts match pulses from the sequence detector over a programmable window and
// reports the count, a sticky saturation flag and a threshold alarm on a valid/ready port.
module match_window_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  input  logic             match,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             overflow,
  output logic             alarm,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StCount  = 2'b01,
    StReport = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             alarm_q, alarm_d;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    thresh_d  = thresh_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    cnt_out_d = cnt_out_q;
    alarm_d   = alarm_q;
    case (state_q)
      StIdle: begin
        if (start && (win_len != '0)) begin
          state_d  = StCount;
          win_d    = win_len;
          thresh_d = thresh;
          count_d  = '0;
          ovf_d    = 1'b0;
        end
      end
      StCount: begin
        if (match) begin
          if (count_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        win_d = win_q - 1'b1;
        // Last sample edge: publish the count including this edge's match.
        if (win_q == WIN_W'(1)) begin
          state_d   = StReport;
          cnt_out_d = count_d;
          alarm_d   = (count_d >= thresh_q);
        end
      end
      StReport: begin
        if (rd_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      win_q     <= '0;
      thresh_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cnt_out_q <= '0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      thresh_q  <= thresh_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      cnt_out_q <= cnt_out_d;
      alarm_q   <= alarm_d;
    end
  end

  assign cnt_out   = cnt_out_q;
  assign overflow  = ovf_q;
  assign alarm     = alarm_q;
  assign cnt_valid = (state_q == StReport);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_match_window_counter.sv
// Directed bench for match_window_counter: a vector table of whole windows plus
// hand-written backpressure, zero-length and mid-window reset sequences.
module tb_match_window_counter;

  logic       clk = 1'b0;
  logic       reset, start, match, rd_ready;
  logic [7:0] win_len, thresh;

  logic [7:0] cnt_out;
  logic       cnt_valid, overflow, alarm, busy;
  logic [3:0] cnt_out4;
  logic       cnt_valid4, overflow4, alarm4, busy4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  match_window_counter #(.CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .win_len(win_len), .thresh(thresh),
    .match(match), .rd_ready(rd_ready), .cnt_out(cnt_out), .cnt_valid(cnt_valid),
    .overflow(overflow), .alarm(alarm), .busy(busy)
  );

  match_window_counter #(.CNT_W(4), .WIN_W(8)) dut4 (
    .clk(clk), .reset(reset), .start(start), .win_len(win_len), .thresh(thresh[3:0]),
    .match(match), .rd_ready(rd_ready), .cnt_out(cnt_out4), .cnt_valid(cnt_valid4),
    .overflow(overflow4), .alarm(alarm4), .busy(busy4)
  );

  typedef struct {
    string       name;
    logic [7:0]  wl;
    logic [7:0]  th;
    logic [31:0] pat;     // bit 0 = start edge, bit i = sample i
    logic [7:0]  cnt;
    logic        ovf;
    logic        alm;
    logic        narrow;  // check the CNT_W=4 instance
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input vec_t v, input bit do_xfer);
    logic [7:0] c;
    logic       vld, ov, al, bz;
    start   = 1'b1;
    win_len = v.wl;
    thresh  = v.th;
    match   = v.pat[0];
    tick();
    start = 1'b0;
    chk({v.name, " busy after start"}, 32'(v.narrow ? busy4 : busy), 32'd1);
    for (int i = 1; i <= int'(v.wl); i++) begin
      if (i == int'(v.wl)) chk({v.name, " valid not early"},
                               32'(v.narrow ? cnt_valid4 : cnt_valid), 32'd0);
      match = (i < 32) ? v.pat[i] : 1'b1;
      tick();
    end
    match = 1'b0;
    c   = v.narrow ? {4'b0, cnt_out4} : cnt_out;
    vld = v.narrow ? cnt_valid4 : cnt_valid;
    ov  = v.narrow ? overflow4 : overflow;
    al  = v.narrow ? alarm4 : alarm;
    chk({v.name, " cnt_valid"}, 32'(vld), 32'd1);
    chk({v.name, " cnt_out"}, 32'(c), 32'(v.cnt));
    chk({v.name, " overflow"}, 32'(ov), 32'(v.ovf));
    chk({v.name, " alarm"}, 32'(al), 32'(v.alm));
    if (do_xfer) begin
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      bz  = v.narrow ? busy4 : busy;
      vld = v.narrow ? cnt_valid4 : cnt_valid;
      c   = v.narrow ? {4'b0, cnt_out4} : cnt_out;
      chk({v.name, " busy after xfer"}, 32'(bz), 32'd0);
      chk({v.name, " valid after xfer"}, 32'(vld), 32'd0);
      chk({v.name, " cnt_out held"}, 32'(c), 32'(v.cnt));
    end
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    vecs[0] = '{"T1 basic",     8'd10, 8'd3,  32'h0000_0424, 8'd3,  1'b0, 1'b1, 1'b0};
    vecs[1] = '{"T2 edges",     8'd4,  8'd2,  32'h0000_0003, 8'd1,  1'b0, 1'b0, 1'b0};
    vecs[2] = '{"len1 hit",     8'd1,  8'd1,  32'h0000_0002, 8'd1,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{"len1 th0",     8'd1,  8'd0,  32'h0000_0000, 8'd0,  1'b0, 1'b1, 1'b0};
    vecs[4] = '{"below thresh", 8'd8,  8'd9,  32'h0000_01FE, 8'd8,  1'b0, 1'b0, 1'b0};
    vecs[5] = '{"last sample",  8'd31, 8'd1,  32'h8000_0000, 8'd1,  1'b0, 1'b1, 1'b0};
    vecs[6] = '{"T3 saturate",  8'd20, 8'd15, 32'hFFFF_FFFF, 8'd15, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{"T3 clear",     8'd3,  8'd1,  32'h0000_0000, 8'd0,  1'b0, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; match = 1'b0; rd_ready = 1'b0;
    win_len = 8'd0; thresh = 8'd0;
    tick();
    tick();
    chk("reset cnt_out", 32'(cnt_out), 32'd0);
    chk("reset cnt_valid", 32'(cnt_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset alarm", 32'(alarm), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_window(vecs[i], 1'b1);

    // T4: hold the report under backpressure while start is pulsed.
    v = '{"T4 report", 8'd2, 8'd2, 32'h0000_0006, 8'd2, 1'b0, 1'b1, 1'b0};
    run_window(v, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start   = (i % 2) == 0;
      win_len = 8'd5;
      tick();
      chk("T4 valid held", 32'(cnt_valid), 32'd1);
      chk("T4 cnt held", 32'(cnt_out), 32'd2);
      chk("T4 alarm held", 32'(alarm), 32'd1);
    end
    start    = 1'b1;  // coincides with the transfer edge and must be ignored
    rd_ready = 1'b1;
    tick();
    start    = 1'b0;
    rd_ready = 1'b0;
    chk("T4 busy after xfer", 32'(busy), 32'd0);
    chk("T4 valid after xfer", 32'(cnt_valid), 32'd0);
    tick();
    chk("T4 still idle", 32'(busy), 32'd0);

    // T5: zero-length window is ignored.
    start   = 1'b1;
    win_len = 8'd0;
    match   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("T5 busy", 32'(busy), 32'd0);
      chk("T5 valid", 32'(cnt_valid), 32'd0);
    end
    start = 1'b0;
    match = 1'b0;

    // T6: reset three samples into a ten-cycle window.
    start   = 1'b1;
    win_len = 8'd10;
    thresh  = 8'd1;
    tick();
    start = 1'b0;
    match = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    match = 1'b0;
    chk("T6 cnt_out", 32'(cnt_out), 32'd0);
    chk("T6 valid", 32'(cnt_valid), 32'd0);
    chk("T6 busy", 32'(busy), 32'd0);
    chk("T6 alarm", 32'(alarm), 32'd0);
    chk("T6 overflow", 32'(overflow), 32'd0);
    tick();
    chk("T6 idle", 32'(busy), 32'd0);
    v = '{"T6 restart", 8'd2, 8'd3, 32'h0000_0006, 8'd2, 1'b0, 1'b0, 1'b0};
    run_window(v, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
